fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin arbiter that shares the FIFO write port among `NREQ` producers. It grants one requester at a time and holds that grant for a burst. The burst ends on the requester's `last` flag or on a `MAX_BURST` beat limit. The block sits in front of the FIFO write-side interface: its `fifo_wen`/`fifo_wdata` drive the write pointer logic, and it takes `fifo_full` back from it.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: FIFO data width.
- `MAX_BURST`, 8: maximum beats per grant, at least 1.
- `TIMEOUT`, 16: idle-cycle limit for a granted requester. Only used when `FIFO_ARB_TIMEOUT_EN` is defined.

Ports:
- `CLK`  in  1  clock. All logic is on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester data valid.
- `req_data`  in  NREQ*DATA_W  requester i data on bits [i*DATA_W +: DATA_W].
- `req_last`  in  NREQ  marks the final beat of a burst.
- `req_ready`  out  NREQ  beat accepted when `req_valid[i] & req_ready[i]`.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wen`  out  1  FIFO write enable.
- `fifo_wdata`  out  DATA_W  FIFO write data.
- `grant_id`  out  $clog2(NREQ)  current or most recent grantee.
- `busy`  out  1  high while in XFER.

## Operation
State machine with two states, IDLE and XFER.

- **IDLE**
  - If any `req_valid` is high, select the first set bit searching from `last_grant+1` upward, wrapping modulo NREQ.
  - Register `grant_id`, clear `beat_cnt`, go to XFER.
  - If no `req_valid` is high, stay in IDLE.
- **XFER**
  - `req_ready[grant_id] = ~fifo_full`. All other `req_ready` bits are 0.
  - Beat = `req_valid[grant_id] & ~fifo_full`.
  - `fifo_wen` = beat, combinational. `fifo_wdata` = `req_data[grant_id]` (mux).
  - On every beat, `beat_cnt` increments. `beat_cnt` is $clog2(MAX_BURST+1) bits wide and never wraps.
  - Exit to IDLE on a beat where `req_last[grant_id]` is high, or where `beat_cnt == MAX_BURST-1`. On exit, `last_grant <= grant_id`.
  - If the grantee drops `req_valid` while in XFER, the grant stays locked. No other requester is served.
- **Other rules**
  - `fifo_full` high: no beat occurs, the state holds, and the grant is kept.
  - `req_last` on a non-beat cycle (valid low or full) is ignored.
  - Requests from non-granted requesters never influence XFER.

## Timing
- Reset values:
  - state IDLE
  - `last_grant` = NREQ-1, so requester 0 wins first
  - `grant_id` 0, `busy` 0, `fifo_wen` 0
  - `req_ready` all 0, `fifo_wdata` follows the mux of requester 0
- Request-to-first-write latency is 1 cycle: valid seen in IDLE at cycle N, earliest `fifo_wen` at N+1.
- Burst to next burst: one IDLE arbitration cycle between grants. Peak throughput is MAX_BURST/(MAX_BURST+1).
- `fifo_wen`, `req_ready` and `fifo_wdata` are combinational from state and inputs. `grant_id` and `busy` are registered.
- `RST` asserted mid-burst clears the state immediately. `fifo_wen` and `req_ready` drop in the same cycle. A partial burst is not resumed.

## Configuration
- `FIFO_ARB_TIMEOUT_EN` defined:
  - A counter counts consecutive XFER cycles with `req_valid[grant_id]` low. The counter clears on any grantee valid.
  - When the count reaches `TIMEOUT`, the arbiter returns to IDLE and `last_grant <= grant_id`.
  - Cycles stalled on `fifo_full` with valid high do not count.
- Not defined: no counter. The grant is held indefinitely until last or MAX_BURST, as described in Operation.

## Test plan
- **Reset priority:** after reset, requesters 0 and 2 both valid with `req_last` on the first beat. Required: grant 0 at cycle 1, then IDLE, grant 2 at cycle 3, `fifo_wen` high at cycles 1 and 3.
- **Round-robin fairness:** all 4 requesters valid continuously, single-beat bursts. Required: grant order 0,1,2,3,0 with `fifo_wdata` matching each requester's data.
- **Burst cap:** requester 1 streams 20 beats with no `req_last`, MAX_BURST=8. Required: the grant releases after beat 8, re-grants to 1 if it is the only requester, and 20 FIFO writes occur in order.
- **Full stall:** `fifo_full` asserted for 5 cycles mid-burst. Required: `fifo_wen` and `req_ready` are 0 during the stall, grant unchanged, no data lost or duplicated, and the burst resumes on deassert.
- **Reset mid-burst:** assert `RST` at beat 3 of 6. Required: `fifo_wen`, `busy` and `req_ready` are 0 in the same cycle. After release, arbitration restarts from requester 0.
- **Timeout (with `FIFO_ARB_TIMEOUT_EN`, TIMEOUT=16):** the grantee drops valid after 2 beats while requester 3 is valid. Required: the grant releases after 16 idle cycles and requester 3 is granted on the next arbitration. Without the macro, requester 3 is never granted.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ producers, granting bursts.
// Optional idle-grant timeout is compiled in when FIFO_ARB_TIMEOUT_EN is defined.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8,
   parameter int TIMEOUT   = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     fifo_full,
   output logic                     fifo_wen,
   output logic [DATA_W-1:0]        fifo_wdata,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int BCW = $clog2(MAX_BURST+1);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST-1);
   localparam logic [BCW-1:0] BEAT_SAT  = BCW'(MAX_BURST);

   typedef enum logic {IDLE, XFER} state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    gid, gid_nxt;
   logic [IDW-1:0]    last_grant, last_grant_nxt;
   logic [BCW-1:0]    beat_cnt, beat_cnt_nxt;
   logic [IDW-1:0]    pick, idx;
   logic              pick_found;
   logic              beat;
   logic [DATA_W-1:0] data_arr [NREQ];

`ifdef FIFO_ARB_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT+1);
   localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT-1);
   logic [TCW-1:0]    idle_cnt, idle_cnt_nxt;
`endif

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = req_data[i*DATA_W +: DATA_W];
      end
   end

   // Search starts just past the previous grantee so every requester gets a turn.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      idx        = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(last_grant) + k) % NREQ);
         if (!pick_found && req_valid[idx]) begin
            pick       = idx;
            pick_found = 1'b1;
         end
      end
   end

   assign beat       = (state == XFER) && req_valid[gid] && !fifo_full;
   assign fifo_wen   = beat;
   assign fifo_wdata = data_arr[gid];
   assign grant_id   = gid;
   assign busy       = (state == XFER);

   always_comb begin
      req_ready = '0;
      if ((state == XFER) && !fifo_full) begin
         req_ready[gid] = 1'b1;
      end
   end

   always_comb begin
      state_nxt      = state;
      gid_nxt        = gid;
      last_grant_nxt = last_grant;
      beat_cnt_nxt   = beat_cnt;
`ifdef FIFO_ARB_TIMEOUT_EN
      idle_cnt_nxt   = idle_cnt;
`endif
      case (state)
         IDLE: begin
            if (pick_found) begin
               gid_nxt      = pick;
               beat_cnt_nxt = '0;
`ifdef FIFO_ARB_TIMEOUT_EN
               idle_cnt_nxt = '0;
`endif
               state_nxt    = XFER;
            end
         end
         XFER: begin
            if (beat) begin
               if (beat_cnt != BEAT_SAT) begin
                  beat_cnt_nxt = beat_cnt + 1'b1;
               end
               if (req_last[gid] || (beat_cnt == LAST_BEAT)) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = gid;
               end
            end
`ifdef FIFO_ARB_TIMEOUT_EN
            // Only cycles with the grantee's valid low count; full stalls with valid high do not.
            if (req_valid[gid]) begin
               idle_cnt_nxt = '0;
            end else if (idle_cnt == TO_LAST) begin
               idle_cnt_nxt   = '0;
               state_nxt      = IDLE;
               last_grant_nxt = gid;
            end else begin
               idle_cnt_nxt = idle_cnt + 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset leaves last_grant at the top index so requester 0 wins the first arbitration.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         gid        <= '0;
         last_grant <= IDW'(NREQ-1);
         beat_cnt   <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
         idle_cnt   <= '0;
`endif
      end else begin
         state      <= state_nxt;
         gid        <= gid_nxt;
         last_grant <= last_grant_nxt;
         beat_cnt   <= beat_cnt_nxt;
`ifdef FIFO_ARB_TIMEOUT_EN
         idle_cnt   <= idle_cnt_nxt;
`endif
      end
   end

endmodule
